// File: rtl/reg_rw.sv
// XLEN-wide storage register with write enable.
// Basic cell for the register file and CSR-style read/write registers.
module reg_rw #(
   parameter int               XLEN        = 32,
   parameter logic [XLEN-1:0]  RESET_VALUE = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wenble,
   input  logic [XLEN-1:0] datain,
   output logic [XLEN-1:0] dataout
);

   // dataout is the flop itself, so there is no path from datain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataout <= RESET_VALUE;
      end else if (wenble) begin
         dataout <= datain;
      end
   end

endmodule

// File: tb/tb_reg_rw.sv
// Bench for reg_rw: directed vector table, async reset sequences,
// and random traffic checked against a one-word storage model.
module tb_reg_rw;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RST_VAL = '0;

   logic            clk;
   logic            rst_n;
   logic            wenble;
   logic [XLEN-1:0] datain;
   logic [XLEN-1:0] dataout;

   int n_checks = 0;
   int n_fails  = 0;

   reg_rw #(
      .XLEN        (XLEN),
      .RESET_VALUE (RST_VAL)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wenble  (wenble),
      .datain  (datain),
      .dataout (dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic            rst_n;
      logic            wen;
      logic [XLEN-1:0] din;
      logic [XLEN-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name,
                        input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: dataout=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive away from the rising edge, then sample just after it.
   task automatic apply(input logic r,
                        input logic w,
                        input logic [XLEN-1:0] d);
      @(negedge clk);
      rst_n  = r;
      wenble = w;
      datain = d;
      @(posedge clk);
      #1;
   endtask

   logic [XLEN-1:0] model;

   initial begin
      rst_n  = 1'b0;
      wenble = 1'b0;
      datain = '0;

      vecs.push_back('{"rst0",      1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{"rst1",      1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{"release",   1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{"hold_aa",   1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_0000});
      vecs.push_back('{"wr_aa",     1'b1, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA});
      vecs.push_back('{"keep_aa",   1'b1, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA});
      vecs.push_back('{"hold_55",   1'b1, 1'b0, 32'h5555_5555, 32'hAAAA_AAAA});
      vecs.push_back('{"wr_55",     1'b1, 1'b1, 32'h5555_5555, 32'h5555_5555});
      vecs.push_back('{"same_55",   1'b1, 1'b1, 32'h5555_5555, 32'h5555_5555});
      vecs.push_back('{"hold_0",    1'b1, 1'b0, 32'h0000_0000, 32'h5555_5555});
      vecs.push_back('{"wr_0",      1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000});
      vecs.push_back('{"hold_ff",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000});
      vecs.push_back('{"wr_ff",     1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{"keep_ff",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{"dchg_ff",   1'b1, 1'b0, 32'h0BAD_F00D, 32'hFFFF_FFFF});

      #2;
      check("rst_initial", dataout, RST_VAL);

      foreach (vecs[i]) begin
         apply(vecs[i].rst_n, vecs[i].wen, vecs[i].din);
         check(vecs[i].name, dataout, vecs[i].exp);
      end

      // Reset dropped between edges must clear before the next rise.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst", dataout, RST_VAL);
      wenble = 1'b1;
      datain = 32'h1234_5678;
      @(posedge clk);
      #1;
      check("wr_in_rst", dataout, RST_VAL);

      apply(1'b1, 1'b1, 32'h0000_0001);
      check("burst1", dataout, 32'h0000_0001);
      apply(1'b1, 1'b1, 32'h0000_0002);
      check("burst2", dataout, 32'h0000_0002);
      apply(1'b1, 1'b1, 32'h0000_0003);
      check("burst3", dataout, 32'h0000_0003);

      // Reset and write in the same cycle: reset wins.
      apply(1'b0, 1'b1, 32'hDEAD_BEEF);
      check("rst_vs_wr", dataout, RST_VAL);
      apply(1'b1, 1'b0, 32'hDEAD_BEEF);
      check("post_rst_hold", dataout, RST_VAL);

      // Random traffic against a single stored-word model.
      model = RST_VAL;
      for (int i = 0; i < 300; i++) begin
         logic            r;
         logic            w;
         logic [XLEN-1:0] d;
         r = ($urandom_range(0, 15) != 0);
         w = $urandom_range(0, 1) == 1;
         d = $urandom;
         @(negedge clk);
         rst_n  = r;
         wenble = w;
         datain = d;
         if (!r) begin
            model = RST_VAL;
            #1;
            check("rnd_async", dataout, model);
         end
         @(posedge clk);
         #1;
         if (r && w) model = d;
         check("rnd_edge", dataout, model);
      end

      @(negedge clk);
      wenble = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/reg_rw.md
# reg_rw

Single XLEN-wide read/write register with write enable, used as the basic storage element of the core's register file and CSR-style read/write registers. On a clock edge with write enable asserted, it captures the input word. Its stored value is continuously visible on the output. It is purely a storage primitive: no address decode, no byte lanes, no read-side logic.

## Interface

Clock and reset:
- One clock. Reset is asynchronous and active-low. Ports are named clk and rst_n.

Parameters:
- XLEN, 32 (taken from core_general.vh): data width in bits.
- RESET_VALUE, {XLEN{1'b0}}: value loaded into the register while reset is asserted.

Ports, in positional order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- wenble  input  1  write enable, active-high, sampled on the rising edge of clk.
- datain  input  XLEN  write data, sampled on the rising edge of clk.
- dataout  output  XLEN  current stored value, driven directly from the register (no combinational path from datain).

## Operation

- rst_n = 0:
  - The register is forced to RESET_VALUE immediately, without waiting for a clock edge.
  - dataout = RESET_VALUE (0x00000000 by default).
  - wenble and datain are ignored.
- rst_n = 1, rising edge of clk with wenble = 1: register ← datain. All XLEN bits are written; there is no partial write.
- rst_n = 1, rising edge of clk with wenble = 0: register holds its value.
- Changes on datain while wenble = 0 never affect dataout.
- Writing the value already stored is legal and leaves dataout unchanged.
- X on wenble at a clock edge: behaviour is not specified. Benches must drive wenble to a known value at all times.

## Timing

- Write latency is one edge: a write sampled at edge N is visible on dataout immediately after edge N and stays stable until the next write edge or reset.
- dataout is fully registered. It changes only on a rising clk edge where wenble = 1, or asynchronously when rst_n falls.
- Reset release:
  - rst_n rising is synchronized by the system, not by this block.
  - The first write can occur on the first rising edge at which rst_n = 1.
- Reset asserted in the same cycle as a write: reset wins, and dataout = RESET_VALUE.
- Reset asserted mid-hold: dataout goes to RESET_VALUE at once and stays there until a write after reset is released.
- Setup and hold on wenble and datain are relative to the rising edge of clk. Stimulus must change these signals away from the edge, e.g. on the falling edge or after a delta.

## Test plan

- Reset:
  - Hold rst_n = 0 for 2 clocks with datain = 0x00000000 and wenble = 0, then release.
  - Required: dataout = 0x00000000 throughout reset and after release.
- Hold without enable:
  - With wenble = 0, set datain = 0xAAAAAAAA and wait one clock. Required: dataout stays 0x00000000.
  - Then pulse wenble = 1 for one clock. Required: dataout = 0xAAAAAAAA after that edge, and it stays there after wenble returns to 0.
- Pattern toggle:
  - With wenble = 0, set datain = 0x55555555 and wait one clock. Required: dataout stays 0xAAAAAAAA.
  - Then pulse wenble for one clock. Required: dataout = 0x55555555.
- Zero and all-ones:
  - Write 0x00000000 using the same set-then-pulse sequence. Required: dataout = 0x00000000.
  - Then write 0xFFFFFFFF the same way. Required: dataout = 0xFFFFFFFF, and it is held afterwards with wenble = 0.
- Asynchronous reset mid-operation:
  - With dataout = 0xFFFFFFFF, drop rst_n between clock edges. Required: dataout = 0x00000000 before the next rising edge.
  - Assert wenble = 1 with datain = 0x12345678 while rst_n = 0. Required: dataout stays 0x00000000.
- Reset vs. write priority and continuous write:
  - Release rst_n, then hold wenble = 1 for 3 clocks with datain = 0x1, 0x2, 0x3 on successive cycles. Required: dataout follows 0x1, 0x2, 0x3, each value appearing one edge after it is applied.
